// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Control-state sequencer for the multicycle CPU. Walks the microcode ROM
//   address (states 0-14) from opcode/funct decode and memory handshaking,
//   flags the final state of each instruction, counts retired instructions
//   and latches a sticky illegal-opcode flag.
//
//   Optional feature: define MICROSEQ_ILLEGAL_TRAP_EN to park the sequencer in
//   TRAP_STATE on an illegal opcode (held until reset). Without it, an illegal
//   opcode returns to fetch and execution carries on.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   run        in   permit a new fetch to start from state 0
//   opcode     in   IR[31:26]
//   funct      in   IR[5:0]
//   mem_ready  in   memory access completes this cycle
//   state      out  microcode ROM address
//   instr_done out  high during the final cycle of an instruction
//   illegal    out  sticky illegal-opcode flag
//   retired    out  completed-instruction count (wraps)
module micro_sequencer #(
  parameter int          COUNT_W    = 16,
  parameter logic [4:0]  TRAP_STATE = 5'd15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic [4:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;

  logic [4:0] next;
  logic       bad_op;
  logic       term_q;   // sitting in a terminal state that needs no handshake

  always_comb begin
    next   = state;
    bad_op = 1'b0;
    case (state)
      5'd0:  if (run && mem_ready) next = 5'd1;
      5'd1: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI:  next = 5'd2;
          OP_RTYPE:               next = (funct == FN_MFLO) ? 5'd14 : 5'd6;
          OP_BEQ:                 next = 5'd8;
          OP_BNE:                 next = 5'd11;
          OP_J:                   next = 5'd9;
          OP_ANDI, OP_ORI, OP_SLTI: next = 5'd12;
          default: begin
            bad_op = 1'b1;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
            next   = TRAP_STATE;
`else
            next   = 5'd0;
`endif
          end
        endcase
      end
      // opcode re-decoded here; anything unexpected takes the ALU-writeback path
      5'd2: begin
        case (opcode)
          OP_LW:   next = 5'd3;
          OP_SW:   next = 5'd5;
          default: next = 5'd10;
        endcase
      end
      5'd3:  if (mem_ready) next = 5'd4;
      5'd5:  if (mem_ready) next = 5'd0;
      5'd6:  next = (funct == FN_MULT) ? 5'd13 : 5'd7;
      5'd12: next = 5'd10;
      5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14: next = 5'd0;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
      TRAP_STATE: next = TRAP_STATE;
`else
      TRAP_STATE: next = 5'd0;
`endif
      default: next = 5'd0;   // unused encodings recover to fetch
    endcase
  end

  // Non-memory terminals are known one edge ahead, so their done flag is a
  // register. State 5 finishes on the cycle mem_ready arrives, which cannot be
  // known in advance, so that handshake is folded in here.
  assign instr_done = term_q | ((state == 5'd5) & mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= 5'd0;
      term_q  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= next;
      case (next)
        5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14: term_q <= 1'b1;
        default:                                              term_q <= 1'b0;
      endcase
      if (bad_op)     illegal <= 1'b1;
      if (instr_done) retired <= retired + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Directed scoreboard bench. Each stimulus step pushes the hand-derived
//   outputs for that cycle; a negedge monitor pops and compares.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready;
  logic [5:0] opcode, funct;
  logic [4:0] state;
  logic       instr_done, illegal;
  logic [3:0] retired;

  micro_sequencer #(.COUNT_W(4), .TRAP_STATE(5'd15)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .state(state), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] st;
    logic       done;
    logic       ill;
    logic [3:0] ret;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_ret = 4'd0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (state !== e.st || instr_done !== e.done || illegal !== e.ill || retired !== e.ret) begin
        errors++;
        $display("FAIL %s: got state=%0d done=%0b illegal=%0b retired=%0d, expected state=%0d done=%0b illegal=%0b retired=%0d",
                 e.nm, state, instr_done, illegal, retired, e.st, e.done, e.ill, e.ret);
      end
    end
  end

  // One clock of stimulus; expected values describe the cycle being driven.
  task automatic step(input logic rs, input logic r, input logic [5:0] op,
                      input logic [5:0] fn, input logic mr, input logic [4:0] es,
                      input logic ed, input logic ei, input string nm);
    exp_t e;
    reset = rs; run = r; opcode = op; funct = fn; mem_ready = mr;
    if (!rs) exp_ret = 4'd0;
    e.st = es; e.done = ed; e.ill = ei; e.ret = exp_ret; e.nm = nm;
    sb.push_back(e);
    if (ed) exp_ret = exp_ret + 4'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, "reset");
    // fetch holds without run, and without mem_ready
    step(1, 0, 6'h23, 6'h00, 1, 0, 0, 0, "hold_norun");
    step(1, 1, 6'h23, 6'h00, 0, 0, 0, 0, "hold_nomem");
    // T1 lw
    step(1, 1, 6'h23, 6'h00, 1, 0, 0, 0, "t1_s0");
    step(1, 1, 6'h23, 6'h00, 1, 1, 0, 0, "t1_s1");
    step(1, 1, 6'h23, 6'h00, 1, 2, 0, 0, "t1_s2");
    step(1, 1, 6'h23, 6'h00, 1, 3, 0, 0, "t1_s3");
    step(1, 1, 6'h23, 6'h00, 1, 4, 1, 0, "t1_s4");
    // T2 sw with two-cycle memory stall
    step(1, 1, 6'h2B, 6'h00, 1, 0, 0, 0, "t2_s0");
    step(1, 1, 6'h2B, 6'h00, 1, 1, 0, 0, "t2_s1");
    step(1, 1, 6'h2B, 6'h00, 1, 2, 0, 0, "t2_s2");
    step(1, 1, 6'h2B, 6'h00, 0, 5, 0, 0, "t2_s5a");
    step(1, 1, 6'h2B, 6'h00, 0, 5, 0, 0, "t2_s5b");
    step(1, 1, 6'h2B, 6'h00, 1, 5, 1, 0, "t2_s5c");
    // T3 R-type: mult, mflo, add
    step(1, 1, 6'h00, 6'h18, 1, 0, 0, 0, "t3m_s0");
    step(1, 1, 6'h00, 6'h18, 1, 1, 0, 0, "t3m_s1");
    step(1, 1, 6'h00, 6'h18, 1, 6, 0, 0, "t3m_s6");
    step(1, 1, 6'h00, 6'h18, 1, 13, 1, 0, "t3m_s13");
    step(1, 1, 6'h00, 6'h12, 1, 0, 0, 0, "t3f_s0");
    step(1, 1, 6'h00, 6'h12, 1, 1, 0, 0, "t3f_s1");
    step(1, 1, 6'h00, 6'h12, 1, 14, 1, 0, "t3f_s14");
    step(1, 1, 6'h00, 6'h20, 1, 0, 0, 0, "t3a_s0");
    step(1, 1, 6'h00, 6'h20, 1, 1, 0, 0, "t3a_s1");
    step(1, 1, 6'h00, 6'h20, 1, 6, 0, 0, "t3a_s6");
    step(1, 1, 6'h00, 6'h20, 1, 7, 1, 0, "t3a_s7");
    // branches, addi, immediate-ALU
    step(1, 1, 6'h04, 6'h00, 1, 0, 0, 0, "beq_s0");
    step(1, 1, 6'h04, 6'h00, 1, 1, 0, 0, "beq_s1");
    step(1, 1, 6'h04, 6'h00, 1, 8, 1, 0, "beq_s8");
    step(1, 1, 6'h05, 6'h00, 1, 0, 0, 0, "bne_s0");
    step(1, 1, 6'h05, 6'h00, 1, 1, 0, 0, "bne_s1");
    step(1, 1, 6'h05, 6'h00, 1, 11, 1, 0, "bne_s11");
    step(1, 1, 6'h08, 6'h00, 1, 0, 0, 0, "addi_s0");
    step(1, 1, 6'h08, 6'h00, 1, 1, 0, 0, "addi_s1");
    step(1, 1, 6'h08, 6'h00, 1, 2, 0, 0, "addi_s2");
    step(1, 1, 6'h08, 6'h00, 1, 10, 1, 0, "addi_s10");
    step(1, 1, 6'h0C, 6'h00, 1, 0, 0, 0, "andi_s0");
    step(1, 1, 6'h0C, 6'h00, 1, 1, 0, 0, "andi_s1");
    step(1, 1, 6'h0C, 6'h00, 1, 12, 0, 0, "andi_s12");
    step(1, 1, 6'h0C, 6'h00, 1, 10, 1, 0, "andi_s10");
    // T6: 16 jumps, counter passes 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 6'h02, 6'h00, 1, 0, 0, 0, "t6_s0");
      step(1, 1, 6'h02, 6'h00, 1, 1, 0, 0, "t6_s1");
      step(1, 1, 6'h02, 6'h00, 1, 9, 1, 0, "t6_s9");
    end
    // T4 illegal opcode
    step(1, 1, 6'h3F, 6'h00, 1, 0, 0, 0, "t4_s0");
    step(1, 1, 6'h3F, 6'h00, 1, 1, 0, 0, "t4_s1");
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step(1, 1, 6'h23, 6'h00, 1, 15, 0, 1, "t4_trap");
`else
    step(1, 1, 6'h23, 6'h00, 1, 0, 0, 1, "t4_back0");
    step(1, 1, 6'h23, 6'h00, 1, 1, 0, 1, "t4_cont_s1");
    step(1, 1, 6'h23, 6'h00, 1, 2, 0, 1, "t4_cont_s2");
    step(1, 1, 6'h23, 6'h00, 1, 3, 0, 1, "t4_cont_s3");
    step(1, 1, 6'h23, 6'h00, 1, 4, 1, 1, "t4_cont_s4");
    step(1, 0, 6'h23, 6'h00, 1, 0, 0, 1, "t4_sticky");
`endif
    // T5 reset during a stalled lw read
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, "t5_rst0");
    step(1, 1, 6'h23, 6'h00, 1, 0, 0, 0, "t5_s0");
    step(1, 1, 6'h23, 6'h00, 1, 1, 0, 0, "t5_s1");
    step(1, 1, 6'h23, 6'h00, 1, 2, 0, 0, "t5_s2");
    step(1, 1, 6'h23, 6'h00, 0, 3, 0, 0, "t5_s3stall");
    step(1, 1, 6'h23, 6'h00, 0, 3, 0, 0, "t5_s3stall2");
    step(0, 1, 6'h23, 6'h00, 0, 0, 0, 0, "t5_rst_mid");
    step(1, 0, 6'h23, 6'h00, 1, 0, 0, 0, "t5_idle_a");
    step(1, 0, 6'h23, 6'h00, 1, 0, 0, 0, "t5_idle_b");
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
